// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM behind a request/busy handshake with
// fixed read and write wait-state counts and a one-cycle response state.
module mem_responder #(
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic        mem_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RESP} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [AW-1:0] idx, req_idx, resp_idx;
    logic oor, req_oor, resp_oor;
    logic wr_acc, rd_acc, lat0, go_resp, resp_rd;
    logic [31:0] ram [DEPTH_WORDS];
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^mem_addr[1:0];
    always_comb begin
        wr_acc    = state == IDLE && mem_wmask != 4'h0;
        rd_acc    = state == IDLE && mem_wmask == 4'h0 && mem_rstrb;
        req_idx   = mem_addr[AW+1:2];
        req_oor   = mem_addr[31:AW+2] != '0;
        lat0      = rd_acc ? READ_LATENCY == 0 : WRITE_LATENCY == 0;
        go_resp   = ((wr_acc || rd_acc) && lat0) ||
                    ((state == READ_WAIT || state == WRITE_WAIT) && cnt == 4'd1);
        resp_rd   = state == IDLE ? rd_acc : state == READ_WAIT;
        resp_oor  = state == IDLE ? req_oor : oor;
        resp_idx  = state == IDLE ? req_idx : idx;
        mem_rbusy = rd_acc || state == READ_WAIT;
        mem_wbusy = wr_acc || state == WRITE_WAIT;
    end
    // Writes land at the accept edge, so later address changes cannot matter
    always_ff @(posedge clk)
        if (reset && wr_acc && !req_oor)
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) ram[req_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_rdata <= 32'h0;
            mem_err   <= 1'b0;
        end else begin
            mem_err <= go_resp && resp_oor;
            if (go_resp && resp_rd) mem_rdata <= resp_oor ? 32'h0 : ram[resp_idx];
            case (state)
                IDLE: if (wr_acc || rd_acc) begin
                    idx   <= req_idx;
                    oor   <= req_oor;
                    cnt   <= rd_acc ? 4'(READ_LATENCY) : 4'(WRITE_LATENCY);
                    state <= lat0 ? RESP : rd_acc ? READ_WAIT : WRITE_WAIT;
                end
                READ_WAIT, WRITE_WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= go_resp ? RESP : state;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed transaction table plus hand sequences for
// write/read priority, mid-read reset and a zero-latency build.
module tb_mem_responder;
    logic clk = 1'b0, reset = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
    logic [3:0]  mem_wmask = '0;
    logic        mem_rstrb = 1'b0, mem_rbusy, mem_wbusy, mem_err;
    logic [31:0] z_addr = '0, z_wdata = '0, z_rdata;
    logic [3:0]  z_wmask = '0;
    logic        z_rstrb = 1'b0, z_rbusy, z_wbusy, z_err;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_responder u_dut (.clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .mem_err(mem_err));

    mem_responder #(.DEPTH_WORDS(16), .READ_LATENCY(0), .WRITE_LATENCY(0)) u_z (
        .clk(clk), .reset(reset), .mem_addr(z_addr), .mem_wdata(z_wdata),
        .mem_wmask(z_wmask), .mem_rstrb(z_rstrb), .mem_rdata(z_rdata),
        .mem_rbusy(z_rbusy), .mem_wbusy(z_wbusy), .mem_err(z_err));

    typedef struct {
        logic        w;
        logic [31:0] addr, wdata;
        logic [3:0]  wmask;
        int          exp_nb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Runs one transaction; nb counts cycles with the matching busy high,
    // and rd/er are sampled in the first cycle where busy has dropped.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output int nb, output logic [31:0] rd, output logic er);
        @(negedge clk);
        mem_addr = a; mem_wdata = d; mem_wmask = w ? m : 4'h0; mem_rstrb = !w;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (w ? mem_wbusy : mem_rbusy) nb++;
            else break;
            @(negedge clk);
            mem_wmask = 4'h0; mem_rstrb = 1'b0; mem_addr = 32'hFFFF_FFF0; mem_wdata = 32'h0;
        end
        rd = mem_rdata; er = mem_err;
    endtask

    vec_t vecs[$];
    int nb;
    logic [31:0] rd;
    logic er;

    initial begin
        vecs = '{
            '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 2, 32'h0, 1'b0},
            '{1'b0, 32'h10,  32'h0,        4'h0, 3, 32'hDEADBEEF, 1'b0},
            '{1'b1, 32'h20,  32'h11223344, 4'hF, 2, 32'h0, 1'b0},
            '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 2, 32'h0, 1'b0},
            '{1'b0, 32'h20,  32'h0,        4'h0, 3, 32'h11BB33DD, 1'b0},
            '{1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 2, 32'h0, 1'b0},
            '{1'b1, 32'h1000, 32'h12345678, 4'hF, 2, 32'h0, 1'b1},
            '{1'b0, 32'h1000, 32'h0,       4'h0, 3, 32'h0, 1'b1},
            '{1'b0, 32'h0,   32'h0,        4'h0, 3, 32'hCAFEF00D, 1'b0},
            '{1'b0, 32'h13,  32'h0,        4'h0, 3, 32'hDEADBEEF, 1'b0},
            '{1'b1, 32'hFFC, 32'h0A0B0C0D, 4'hF, 2, 32'h0, 1'b0},
            '{1'b1, 32'hFFC, 32'hFFFFFFFF, 4'h2, 2, 32'h0, 1'b0},
            '{1'b0, 32'hFFC, 32'h0,        4'h0, 3, 32'h0A0BFF0D, 1'b0},
            '{1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 3, 32'h0, 1'b1}
        };
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("reset rdata", mem_rdata, 32'h0);
        chk("reset err", 32'(mem_err), 32'h0);
        chk("reset rbusy", 32'(mem_rbusy), 32'h0);
        chk("reset wbusy", 32'(mem_wbusy), 32'h0);
        chk("reset z_rdata", z_rdata, 32'h0);

        foreach (vecs[k]) begin
            txn(vecs[k].w, vecs[k].addr, vecs[k].wdata, vecs[k].wmask, nb, rd, er);
            chk($sformatf("vec%0d busy cycles", k), 32'(nb), 32'(vecs[k].exp_nb));
            chk($sformatf("vec%0d err", k), 32'(er), 32'(vecs[k].exp_err));
            if (!vecs[k].w) chk($sformatf("vec%0d rdata", k), rd, vecs[k].exp_rdata);
        end

        // Concurrent write and read: write wins, read is served after RESP
        @(negedge clk);
        mem_addr = 32'h40; mem_wdata = 32'h5A5A1234; mem_wmask = 4'hF; mem_rstrb = 1'b1;
        #1; chk("both acc wbusy", 32'(mem_wbusy), 32'h1); chk("both acc rbusy", 32'(mem_rbusy), 32'h0);
        @(negedge clk); mem_wmask = 4'h0; mem_addr = 32'h40;
        #1; chk("both wait wbusy", 32'(mem_wbusy), 32'h1); chk("both wait rbusy", 32'(mem_rbusy), 32'h0);
        @(negedge clk);
        #1; chk("both resp wbusy", 32'(mem_wbusy), 32'h0); chk("both resp rbusy", 32'(mem_rbusy), 32'h0);
        @(negedge clk);
        #1; chk("pend read acc", 32'(mem_rbusy), 32'h1);
        @(negedge clk); mem_rstrb = 1'b0;
        #1; chk("pend read w1", 32'(mem_rbusy), 32'h1);
        @(negedge clk);
        #1; chk("pend read w2", 32'(mem_rbusy), 32'h1);
        @(negedge clk);
        #1; chk("pend read resp rbusy", 32'(mem_rbusy), 32'h0);
        chk("pend read rdata", mem_rdata, 32'h5A5A1234);

        // Reset during READ_WAIT aborts the read; RAM survives
        txn(1'b1, 32'h8, 32'h600DF00D, 4'hF, nb, rd, er);
        txn(1'b0, 32'h10, 32'h0, 4'h0, nb, rd, er);
        chk("pre-abort rdata", rd, 32'hDEADBEEF);
        @(negedge clk); mem_addr = 32'h8; mem_rstrb = 1'b1;
        @(negedge clk); mem_rstrb = 1'b0; reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1;
        chk("abort rbusy", 32'(mem_rbusy), 32'h0);
        chk("abort rdata", mem_rdata, 32'h0);
        chk("abort err", 32'(mem_err), 32'h0);
        @(negedge clk);
        #1; chk("abort no resp err", 32'(mem_err), 32'h0);
        chk("abort rdata holds", mem_rdata, 32'h0);
        txn(1'b0, 32'h8, 32'h0, 4'h0, nb, rd, er);
        chk("persist rdata", rd, 32'h600DF00D);
        chk("persist busy", 32'(nb), 32'h3);

        // Zero-latency build: one busy cycle, held read re-accepted every 2 cycles
        @(negedge clk); z_addr = 32'h4; z_wdata = 32'h77; z_wmask = 4'hF;
        #1; chk("z write wbusy", 32'(z_wbusy), 32'h1);
        @(negedge clk); z_wmask = 4'h0; z_rstrb = 1'b1;
        #1; chk("z write resp wbusy", 32'(z_wbusy), 32'h0);
        chk("z resp ignores rstrb", 32'(z_rbusy), 32'h0);
        @(negedge clk);
        #1; chk("z read acc1", 32'(z_rbusy), 32'h1);
        @(negedge clk);
        #1; chk("z read resp1", 32'(z_rbusy), 32'h0); chk("z rdata1", z_rdata, 32'h77);
        @(negedge clk); z_addr = 32'h40;
        #1; chk("z read acc2", 32'(z_rbusy), 32'h1);
        @(negedge clk); z_rstrb = 1'b0;
        #1; chk("z read resp2", 32'(z_rbusy), 32'h0);
        chk("z oor rdata", z_rdata, 32'h0); chk("z oor err", 32'(z_err), 32'h1);
        @(negedge clk);
        #1; chk("z err one cycle", 32'(z_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    always @(negedge clk) begin
        #2;
        if (reset && mem_rbusy && mem_wbusy) begin
            n_cmp++; n_bad++;
            $display("FAIL busy exclusive: got rbusy=1 wbusy=1 required not both");
        end
    end
endmodule
